// File: rtl/instrumented_adder_meter.sv
// instrumented_adder_meter: measurement controller for the instrumented adder
// ring-oscillator experiment. Latches adder operands, enables the rings, lets
// them settle, then counts synchronised rising edges per channel over a gate
// window. Optional sum check is enabled by defining INSTR_ADDER_SUM_CHECK_EN.

// Per-channel tap synchroniser, rise detector and saturating edge counter.
module iam_chan #(
  parameter int CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_clr_ovf,
  input  logic             i_cnt_en,
  input  logic             i_ring,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);
  // r_sync[1:0] is the two-flop synchroniser, r_sync[2] the previous value
  logic [2:0] r_sync;
  logic       w_rise;
  logic       w_max;

  assign w_rise = r_sync[1] & ~r_sync[2];
  assign w_max  = &o_count;

  // Synchronise the asynchronous ring tap and keep one cycle of history
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], i_ring};
  end

  // Saturating edge counter; an edge arriving at full scale flags overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (i_clr)                          o_count <= '0;
      else if (i_cnt_en && w_rise && !w_max) o_count <= o_count + CNT_W'(1);
      if (i_clr_ovf)                      o_ovf <= 1'b0;
      else if (i_cnt_en && w_rise && w_max)  o_ovf <= 1'b1;
    end
  end
endmodule

module instrumented_adder_meter #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 24,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      active,
  input  logic                      start_i,
  input  logic [WIN_W-1:0]          window_i,
  input  logic [WIDTH-1:0]          a_i,
  input  logic [WIDTH-1:0]          b_i,
  input  logic [WIDTH-1:0]          sum_i,
  input  logic [CHANNELS-1:0]       ring_i,
  output logic [WIDTH-1:0]          a_o,
  output logic [WIDTH-1:0]          b_o,
  output logic [CHANNELS-1:0]       ring_en_o,
  output logic [CHANNELS*CNT_W-1:0] count_o,
  output logic [CHANNELS-1:0]       ovf_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      sum_err_o
);
  localparam int ST_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [ST_W-1:0]  r_set_cnt;
  logic [WIN_W-1:0] r_window;
  logic [WIN_W-1:0] r_win_cnt;
  logic             w_start;
  logic             w_abort;
  logic             w_set_last;
  logic             w_cnt_last;
  logic             w_cnt_en;

  assign w_start    = (r_state == S_IDLE) && active && start_i;
  assign w_abort    = !active && ((r_state == S_SETTLE) || (r_state == S_COUNT));
  assign w_set_last = (r_set_cnt == ST_W'(SETTLE_CYC - 1));
  // <= 1 rather than == 1 so a zero count can never keep COUNT alive
  assign w_cnt_last = (r_win_cnt <= WIN_W'(1));
  assign w_cnt_en   = (r_state == S_COUNT);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    ring_en_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy_o    = 1'b1;
        ring_en_o = '1;
        if (!active)         w_next = S_IDLE;
        else if (w_set_last) w_next = (r_window == '0) ? S_DONE : S_COUNT;
      end
      S_COUNT: begin
        busy_o    = 1'b1;
        ring_en_o = '1;
        if (!active)         w_next = S_IDLE;
        else if (w_cnt_last) w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/window latch on start, settle up-counter, window down-counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_o       <= '0;
      b_o       <= '0;
      r_window  <= '0;
      r_win_cnt <= '0;
      r_set_cnt <= '0;
    end else if (w_start) begin
      a_o       <= a_i;
      b_o       <= b_i;
      r_window  <= window_i;
      r_win_cnt <= window_i;
      r_set_cnt <= '0;
    end else begin
      if ((r_state == S_SETTLE) && !w_set_last) r_set_cnt <= r_set_cnt + ST_W'(1);
      if ((r_state == S_COUNT) && (r_win_cnt != '0)) r_win_cnt <= r_win_cnt - WIN_W'(1);
    end
  end

  // One counter instance per ring tap; abort clears counts, only start clears overflow
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    iam_chan #(.CNT_W(CNT_W)) u_chan (
      .i_clk     (wb_clk_i),
      .i_rst     (wb_rst_i),
      .i_clr     (w_start | w_abort),
      .i_clr_ovf (w_start),
      .i_cnt_en  (w_cnt_en),
      .i_ring    (ring_i[ch]),
      .o_count   (count_o[ch*CNT_W +: CNT_W]),
      .o_ovf     (ovf_o[ch])
    );
  end

`ifdef INSTR_ADDER_SUM_CHECK_EN
  logic [WIDTH-1:0] w_sum_ref;
  assign w_sum_ref = a_o + b_o;

  // Sticky adder-result check, sampled once on the last settle cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     sum_err_o <= 1'b0;
    else if (w_start) sum_err_o <= 1'b0;
    else if ((r_state == S_SETTLE) && active && w_set_last && (sum_i != w_sum_ref))
      sum_err_o <= 1'b1;
  end
`else
  logic w_unused_sum;
  assign w_unused_sum = ^sum_i;
  assign sum_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Bench for instrumented_adder_meter: a default instance plus a CNT_W=4
// instance driven with identical stimulus so saturation is reachable.
module tb_instrumented_adder_meter;
  localparam int WIDTH = 32, CH = 2, CNT_W = 24, CNT_S = 4, WIN_W = 16, S = 4;
  localparam int MAXR = 256;
  localparam int SAT_MAX = (1 << CNT_S) - 1;

  logic clk = 1'b0;
  logic rst, active, start;
  logic [WIN_W-1:0] window;
  logic [WIDTH-1:0] a, b, sum;
  logic [CH-1:0]    ring;

  logic [WIDTH-1:0] a_o, b_o, a_o2, b_o2;
  logic [CH-1:0]    ring_en, ring_en2, ovf, ovf2;
  logic [CH*CNT_W-1:0] cnt;
  logic [CH*CNT_S-1:0] cnt2;
  logic busy, busy2, done, done2, serr, serr2;

  instrumented_adder_meter #(.WIDTH(WIDTH), .CHANNELS(CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start_i(start), .window_i(window),
    .a_i(a), .b_i(b), .sum_i(sum), .ring_i(ring), .a_o(a_o), .b_o(b_o), .ring_en_o(ring_en),
    .count_o(cnt), .ovf_o(ovf), .busy_o(busy), .done_o(done), .sum_err_o(serr));

  instrumented_adder_meter #(.WIDTH(WIDTH), .CHANNELS(CH), .CNT_W(CNT_S), .WIN_W(WIN_W), .SETTLE_CYC(S)) u_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start_i(start), .window_i(window),
    .a_i(a), .b_i(b), .sum_i(sum), .ring_i(ring), .a_o(a_o2), .b_o(b_o2), .ring_en_o(ring_en2),
    .count_o(cnt2), .ovf_o(ovf2), .busy_o(busy2), .done_o(done2), .sum_err_o(serr2));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [CH-1:0] R [0:MAXR];   // R[j] = ring value sampled at edge j of a run

  typedef struct {
    int          w, p0, p1;
    bit          hold;
    logic [31:0] av, bv, sv;
    int          e0, e1;
    bit          eserr;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pat(int p, int j);
    if (p == 0) return 1'b0;
    return (j % p) >= (p / 2);
  endfunction

  // Fill the tap history: periodic square waves or random bits
  task automatic gen_r(input bit rnd, input int p0, input int p1, input int len);
    for (int j = 0; j <= len; j++)
      R[j] = rnd ? CH'($urandom) : {pat(p1, j), pat(p0, j)};
  endtask

  // Reference: a tap rise counts when its synchronised copy (2 edges late)
  // shows 0 -> 1 during one of the w COUNT cycles S+1 .. S+w
  function automatic int ref_cnt(int ch, int w);
    int n = 0;
    for (int m = S + 1; m <= S + w; m++)
      if (R[m-2][ch] && !R[m-3][ch]) n++;
    return n;
  endfunction

  function automatic bit exp_serr(logic [31:0] av, logic [31:0] bv, logic [31:0] sv);
`ifdef INSTR_ADDER_SUM_CHECK_EN
    logic [31:0] s;
    s = av + bv;
    return s != sv;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_zero(input string tag);
    chk($sformatf("%s a_o", tag), {a_o, b_o}, 64'd0);
    chk($sformatf("%s a_o2", tag), {a_o2, b_o2}, 64'd0);
    chk($sformatf("%s cnt", tag), cnt, 64'd0);
    chk($sformatf("%s cnt2", tag), cnt2, 64'd0);
    chk($sformatf("%s flags", tag), {ovf, ovf2, ring_en, ring_en2, busy, busy2, done, done2, serr, serr2}, 64'd0);
  endtask

  // One complete measurement: start at edge 0, check every cycle to IDLE
  task automatic do_run(input string tag, input int w, input bit hold,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] sv,
                        input int e0, input int e1, input bit es);
    bit eb, ed;
    @(negedge clk);
    active = 1'b1; start = 1'b1; window = WIN_W'(w);
    a = av; b = bv; sum = sv; ring = R[0];
    for (int c = 1; c <= S + w + 2; c++) begin
      @(negedge clk);
      eb = (c <= S + w);
      ed = (c == S + w + 1);
      chk($sformatf("%s c%0d busy", tag, c), {busy, busy2}, {62'd0, eb, eb});
      chk($sformatf("%s c%0d done", tag, c), {done, done2}, {62'd0, ed, ed});
      chk($sformatf("%s c%0d ring_en", tag, c), {ring_en, ring_en2}, eb ? 64'hF : 64'h0);
      if (c == 1) begin
        chk($sformatf("%s cleared", tag), {cnt, ovf, serr}, 64'd0);
        chk($sformatf("%s cleared2", tag), {cnt2, ovf2, serr2}, 64'd0);
      end
      start = hold && (c <= S + w);
      if (hold) begin
        window = WIN_W'($urandom); a = $urandom; b = $urandom;
      end
      ring = R[c];
    end
    start = 1'b0;
    chk($sformatf("%s cnt0", tag), cnt[CNT_W-1:0], 64'(e0));
    chk($sformatf("%s cnt1", tag), cnt[2*CNT_W-1:CNT_W], 64'(e1));
    chk($sformatf("%s sat0", tag), cnt2[CNT_S-1:0], 64'((e0 > SAT_MAX) ? SAT_MAX : e0));
    chk($sformatf("%s sat1", tag), cnt2[2*CNT_S-1:CNT_S], 64'((e1 > SAT_MAX) ? SAT_MAX : e1));
    chk($sformatf("%s ovf", tag), {ovf, ovf2}, {60'd0, 2'b00, (e1 > SAT_MAX), (e0 > SAT_MAX)});
    chk($sformatf("%s ops", tag), {a_o, b_o}, {av, bv});
    chk($sformatf("%s ops2", tag), {a_o2, b_o2}, {av, bv});
    chk($sformatf("%s sum_err", tag), {serr, serr2}, {62'd0, es, es});
    // results must hold while idle
    repeat (2) @(negedge clk);
    chk($sformatf("%s hold", tag), {cnt[CNT_W-1:0], serr}, {39'd0, 24'(e0), es});
  endtask

  initial begin
    logic [31:0] av, bv, sv;
    int w, e0, e1;

    rst = 1'b1; active = 1'b0; start = 1'b0; window = '0;
    a = '0; b = '0; sum = '0; ring = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // start ignored while inactive
    start = 1'b1; window = 16'd5; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("inactive busy", {busy, busy2, a_o[15:0]}, 64'd0);
    end

    // abort: active drops during COUNT cycle 3 (cycle S+3)
    gen_r(1'b0, 2, 2, MAXR);
    @(negedge clk);
    active = 1'b1; start = 1'b1; window = 16'd10; a = 32'd7; b = 32'd8; sum = 32'd15; ring = R[0];
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == S + 4) begin
        chk("abort busy", {busy, busy2, ring_en, ring_en2}, 64'd0);
        chk("abort cnt", {cnt, cnt2}, 64'd0);
      end
      if (c > S + 3) chk($sformatf("abort c%0d done", c), {done, done2}, 64'd0);
      start = 1'b0;
      if (c == S + 3) active = 1'b0;
      ring = R[c];
    end

    // table-driven runs
    tbl[0] = '{w:10, p0:2, p1:0, hold:0, av:32'd1,         bv:32'd2, sv:32'd3,  e0:5,  e1:0, eserr:0};
    tbl[1] = '{w:0,  p0:2, p1:2, hold:0, av:32'd5,         bv:32'd6, sv:32'd11, e0:0,  e1:0, eserr:0};
    tbl[2] = '{w:40, p0:2, p1:0, hold:0, av:32'hFFFFFFFF,  bv:32'd1, sv:32'd0,  e0:20, e1:0, eserr:0};
    tbl[3] = '{w:12, p0:4, p1:2, hold:1, av:32'hFFFFFFFF,  bv:32'd1, sv:32'd1,  e0:3,  e1:6, eserr:1};
    tbl[4] = '{w:12, p0:1, p1:4, hold:0, av:32'hFFFFFFFF,  bv:32'd1, sv:32'd0,  e0:0,  e1:3, eserr:0};
    for (int i = 0; i < 5; i++) begin
      gen_r(1'b0, tbl[i].p0, tbl[i].p1, MAXR);
      do_run($sformatf("tbl%0d", i), tbl[i].w, tbl[i].hold, tbl[i].av, tbl[i].bv, tbl[i].sv,
             tbl[i].e0, tbl[i].e1, exp_serr(tbl[i].av, tbl[i].bv, tbl[i].sv) & tbl[i].eserr);
    end

    // reset for two cycles in the middle of a run
    gen_r(1'b0, 2, 4, MAXR);
    @(negedge clk);
    active = 1'b1; start = 1'b1; window = 16'd20; a = 32'hA5; b = 32'h5A; sum = 32'h0; ring = R[0];
    for (int c = 1; c <= S + 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c >= S + 4);
      ring = R[c];
    end
    chk_zero("midrun reset");
    rst = 1'b0;

    // randomized runs against the reference model
    for (int i = 0; i < 16; i++) begin
      w  = $urandom_range(0, 30);
      av = $urandom; bv = $urandom;
      sv = ($urandom_range(0, 1) == 1) ? av + bv : $urandom;
      gen_r(1'b1, 0, 0, S + w + 3);
      e0 = ref_cnt(0, w);
      e1 = ref_cnt(1, w);
      do_run($sformatf("rnd%0d", i), w, 1'b0, av, bv, sv, e0, e1, exp_serr(av, bv, sv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
